csa_pipe_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor, the successor to the fixed 4-bit combinational carry-select adder. Operands are split into BLOCK-bit slices, and one slice is resolved per pipeline stage. Each slice is carry-selected from precomputed cin=0/cin=1 sums, and the inter-slice carry is registered. Valid/ready handshakes on both sides let it sit between streaming datapath stages. It also adds subtract mode and signed-overflow detection.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_slice.sv | 36 +++
 rtl/csa_pipe_adder.sv | 111 +++++++++++
 tb/tb_csa_pipe_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and types for the pipelined carry-select adder.
// Sizing helpers live here so the top and the slice agree on defaults.
package csa_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  typedef struct packed {
    logic carry;
    logic sub;
    logic valid;
  } stage_meta_t;

  // One pipeline stage per slice; a bad BLOCK is rejected by the top.
  function automatic int csa_nstg(input int width, input int block);
    return (block > 0) ? width / block : 1;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// One BLOCK-bit carry-select slice: both ripple sums are formed up front,
// and the incoming carry only drives the final mux.
module csa_slice import csa_pkg::*; #(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a_s,
  input  logic [BLOCK-1:0] b_s,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] w_sum0, w_sum1;
  logic [BLOCK:0]   w_c0, w_c1;

  // Two independent ripple chains, seeded with carry 0 and carry 1.
  always_comb begin
    w_sum0  = '0;
    w_sum1  = '0;
    w_c0    = '0;
    w_c1    = '0;
    w_c1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      w_sum0[i]   = a_s[i] ^ b_s[i] ^ w_c0[i];
      w_c0[i+1]   = (a_s[i] & b_s[i]) | (w_c0[i] & (a_s[i] ^ b_s[i]));
      w_sum1[i]   = a_s[i] ^ b_s[i] ^ w_c1[i];
      w_c1[i+1]   = (a_s[i] & b_s[i]) | (w_c1[i] & (a_s[i] ^ b_s[i]));
    end
  end

  assign s        = c_in ? w_sum1 : w_sum0;
  assign c_out    = c_in ? w_c1[BLOCK] : w_c0[BLOCK];
  assign c_msb_in = c_in ? w_c1[BLOCK-1] : w_c0[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one slice resolved per stage,
// registered inter-slice carry, valid/ready on both sides, global stall.
module csa_pipe_adder import csa_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = csa_nstg(WIDTH, BLOCK);

  if (BLOCK < 1) begin : g_badBlock
    $error("csa_pipe_adder: BLOCK must be at least 1");
  end else if (WIDTH % BLOCK != 0) begin : g_badWidth
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
  end

  logic             w_stall;
  logic             r_outValid;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_sum;

  assign w_stall  = r_outValid && !out_ready;
  assign in_ready = !w_stall;

  // Stage k holds finished sum bits below its slice and raw A bits above it
  // in r_acc; r_b shrinks as consumed B slices are dropped.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int BW = WIDTH - k * BLOCK;

    stage_meta_t      r_meta, w_metaIn;
    logic [WIDTH-1:0] r_acc, w_accIn, w_accOut;
    logic [BW-1:0]    r_b, w_bIn;
    logic [BLOCK-1:0] w_s;
    logic             w_cout;
    logic             w_msb;

    if (k == 0) begin : g_head
      assign w_metaIn = '{carry: sub | cin, sub: sub, valid: in_valid};
      assign w_accIn  = a;
      assign w_bIn    = b;
    end else begin : g_body
      assign w_metaIn = '{carry: g_stg[k-1].w_cout,
                          sub:   g_stg[k-1].r_meta.sub,
                          valid: g_stg[k-1].r_meta.valid};
      assign w_accIn  = g_stg[k-1].w_accOut;
      assign w_bIn    = g_stg[k-1].r_b[WIDTH-(k-1)*BLOCK-1:BLOCK];
    end

    // B travels uninverted; the sub flag rides along and inverts each slice.
    csa_slice #(.BLOCK(BLOCK)) u_slice (
      .a_s      (r_acc[k*BLOCK +: BLOCK]),
      .b_s      (r_b[BLOCK-1:0] ^ {BLOCK{r_meta.sub}}),
      .c_in     (r_meta.carry),
      .s        (w_s),
      .c_out    (w_cout),
      .c_msb_in (w_msb)
    );

    always_comb begin
      w_accOut                    = r_acc;
      w_accOut[k*BLOCK +: BLOCK]  = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_meta <= '0;
        r_acc  <= '0;
        r_b    <= '0;
      end else if (!w_stall) begin
        r_meta <= w_metaIn;
        r_acc  <= w_accIn;
        r_b    <= w_bIn;
      end
    end
  end

  // Output register holds the finished beat until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (!w_stall) begin
      r_outValid <= g_stg[NSTG-1].r_meta.valid;
      r_sum      <= g_stg[NSTG-1].w_accOut;
      r_cout     <= g_stg[NSTG-1].w_cout;
      r_ovf      <= g_stg[NSTG-1].w_cout ^ g_stg[NSTG-1].w_msb;
    end
  end

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed cases and a random valid/ready stream,
// each cycle scored against an arithmetic model of a fixed-latency pipe.
module tb_csa_pipe_adder;

  localparam int WIDTH = 16;
  localparam int NSTG  = 4;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             cin, sub, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               readyAt;
  } beat_t;

  beat_t expQ[$];
  int    advCount;
  int    checkCount;
  int    passCount;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of one beat from plain integer arithmetic.
  function automatic beat_t refBeat(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                    input logic ic, input logic is);
    beat_t            r;
    logic [WIDTH-1:0] bEff;
    int               cIn;
    int               uRes;
    int               sRes;
    bEff      = is ? ~ib : ib;
    cIn       = (is || ic) ? 1 : 0;
    uRes      = int'(ia) + int'(bEff) + cIn;
    sRes      = int'($signed(ia)) + int'($signed(bEff)) + cIn;
    r.sum     = uRes[WIDTH-1:0];
    r.cout    = uRes[WIDTH];
    r.ovf     = (sRes > 32767) || (sRes < -32768);
    r.readyAt = 0;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic expValid;
    expValid = (expQ.size() > 0) && (expQ[0].readyAt <= advCount);
    checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(expValid));
    checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(!(expValid && !out_ready)));
    if (expValid) begin
      checkVal({tag, ".sum"},  32'(sum),  32'(expQ[0].sum));
      checkVal({tag, ".cout"}, 32'(cout), 32'(expQ[0].cout));
      checkVal({tag, ".ovf"},  32'(ovf),  32'(expQ[0].ovf));
    end
  endtask

  // Drive one cycle at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib, input logic ic, input logic is,
                               input logic ordy, input string tag, output logic accepted);
    logic  expValid;
    beat_t nb;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    checkOutput(tag);
    expValid = (expQ.size() > 0) && (expQ[0].readyAt <= advCount);
    accepted = 1'b0;
    @(posedge clk);
    if (!(expValid && !ordy)) begin
      if (expValid) void'(expQ.pop_front());
      advCount++;
      if (iv) begin
        nb         = refBeat(ia, ib, ic, is);
        nb.readyAt = advCount + NSTG;
        expQ.push_back(nb);
        accepted   = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic directedBeat(input string tag, input logic [WIDTH-1:0] ia,
                              input logic [WIDTH-1:0] ib, input logic ic, input logic is,
                              input logic [WIDTH-1:0] eSum, input logic eCout, input logic eOvf);
    logic acc;
    applyStimulus(1'b1, ia, ib, ic, is, 1'b1, {tag, ".issue"}, acc);
    repeat (NSTG) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, {tag, ".wait"}, acc);
    checkVal({tag, ".k_valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, ".k_sum"},   32'(sum),       32'(eSum));
    checkVal({tag, ".k_cout"},  32'(cout),      32'(eCout));
    checkVal({tag, ".k_ovf"},   32'(ovf),       32'(eOvf));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, {tag, ".take"}, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   guard;

    checkCount = 0;
    passCount  = 0;
    advCount   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    sub        = 1'b0;
    out_ready  = 1'b1;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    #1;
    checkVal("reset.out_valid", 32'(out_valid), 32'd0);
    checkVal("reset.sum",       32'(sum),       32'd0);
    checkVal("reset.cout",      32'(cout),      32'd0);
    checkVal("reset.ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset.in_ready",  32'(in_ready),  32'd1);

    $display("[TB] directed beats");
    directedBeat("add",      16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0);
    directedBeat("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directedBeat("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directedBeat("subbor",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directedBeat("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom), 1'b1, "stream", acc);
    repeat (NSTG + 2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "stream.drain", acc);

    $display("[TB] backpressure");
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b1, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom),
                    !(i >= 6 && i < 11), "bp", acc);
    repeat (NSTG + 4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "bp.drain", acc);

    $display("[TB] random stream");
    sent  = 0;
    guard = 0;
    while (sent < 2000 && guard < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(), 1'($urandom),
                    1'($urandom), $urandom_range(0, 3) != 0, "rand", acc);
      if (acc) sent++;
      guard++;
    end
    repeat (NSTG + 4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "rand.drain", acc);

    $display("[TB] reset mid-stream");
    repeat (NSTG + 1)
      applyStimulus(1'b1, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom), 1'b1, "mid", acc);
    #2;
    checkVal("mid.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("mid.async_drop", 32'(out_valid), 32'd0);
    checkVal("mid.sum_clear",  32'(sum),       32'd0);
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NSTG + 4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "post_rst", acc);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
